// File: rtl/pid_control_summer.sv
// rtl/pid_control_summer.sv - PID contribution summer: 2-stage sum, saturation, valid/ready output, clip counter
// Optional rate limiter: define PID_SUMMER_RATE_LIMIT_EN to bound |u(n) - u(n-1)| by MAX_STEP.
module pid_control_summer #(
    parameter int W        = 6,
    parameter int CNT_W    = 8,
    parameter int MAX_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     p_contrib,
    input  logic [W-1:0]     i_contrib,
    input  logic [W-1:0]     d_contrib,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     u,
    output logic             sat,
    output logic [CNT_W-1:0] sat_count
);

    // Two guard bits: the sum of three W-bit signed words always fits in W+2 bits.
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] U_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] U_MIN = {3'b111, {(W-1){1'b0}}};

    logic                 adv;
    logic                 s1_valid;
    logic signed [SW-1:0] s1_sum;
    logic [W-1:0]         s1_d;
    logic signed [SW-1:0] full;
    logic signed [SW-1:0] clipped;
    logic signed [SW-1:0] limited;
    logic [W-1:0]         u_new;
    logic                 sat_new;

    // The whole pipeline moves together whenever the output slot is free or being drained.
    assign adv      = ena & (~out_valid | out_ready);
    assign in_ready = adv & ~rst;

    // Stage 1: partial sum p+i, carry d alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_d     <= '0;
        end else if (adv) begin
            s1_sum   <= {{2{p_contrib[W-1]}}, p_contrib} + {{2{i_contrib[W-1]}}, i_contrib};
            s1_d     <= d_contrib;
            s1_valid <= in_valid & in_ready;
        end
    end

    // Full-precision total and clip to the control-word range.
    always_comb begin
        full    = s1_sum + {{2{s1_d[W-1]}}, s1_d};
        clipped = full;
        if (full > U_MAX) begin
            clipped = U_MAX;
        end else if (full < U_MIN) begin
            clipped = U_MIN;
        end
    end

`ifdef PID_SUMMER_RATE_LIMIT_EN
    localparam logic signed [SW-1:0] STEP = SW'(MAX_STEP);

    logic [W-1:0]         u_prev;
    logic signed [SW-1:0] prev_ext;
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] hi;

    // Slew-limit around the previous output; W+2 bits keep the bounds from wrapping near the rails.
    always_comb begin
        prev_ext = {{2{u_prev[W-1]}}, u_prev};
        lo       = prev_ext - STEP;
        hi       = prev_ext + STEP;
        limited  = clipped;
        if (clipped > hi) begin
            limited = hi;
        end else if (clipped < lo) begin
            limited = lo;
        end
    end

    // Remember the last produced output as the reference for the next step.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_prev <= '0;
        end else if (adv && s1_valid) begin
            u_prev <= u_new;
        end
    end
`else
    // No limiter: the clipped value goes straight out.
    always_comb begin
        limited = clipped;
    end
`endif

    assign u_new   = limited[W-1:0];
    assign sat_new = (limited != full);

    // Stage 2: output register, valid tracking and saturating clip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            u         <= '0;
            sat       <= 1'b0;
            sat_count <= '0;
        end else if (adv) begin
            if (s1_valid) begin
                out_valid <= 1'b1;
                u         <= u_new;
                sat       <= sat_new;
                if (sat_new && (sat_count != {CNT_W{1'b1}})) begin
                    sat_count <= sat_count + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pid_control_summer.sv
// tb/tb_pid_control_summer.sv - scoreboard bench for pid_control_summer
module tb_pid_control_summer;

    localparam int W     = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     p_contrib = '0;
    logic [W-1:0]     i_contrib = '0;
    logic [W-1:0]     d_contrib = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     u;
    logic             sat;
    logic [CNT_W-1:0] sat_count;

    pid_control_summer #(.W(W), .CNT_W(CNT_W), .MAX_STEP(4)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .p_contrib(p_contrib), .i_contrib(i_contrib), .d_contrib(d_contrib),
        .out_valid(out_valid), .out_ready(out_ready),
        .u(u), .sat(sat), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u;
        int sat;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_prev   = 0;
    int   m_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain-integer sum, clamp to [-32,31], optional slew clamp, saturating counter.
    task automatic model_push(input int p, input int i, input int d);
        int   full;
        int   lim;
        exp_t e;
        full = p + i + d;
        lim  = full;
        if (lim > 31) lim = 31;
        if (lim < -32) lim = -32;
`ifdef PID_SUMMER_RATE_LIMIT_EN
        if (lim > m_prev + 4) lim = m_prev + 4;
        if (lim < m_prev - 4) lim = m_prev - 4;
        m_prev = lim;
`endif
        e.u   = lim;
        e.sat = (lim != full) ? 1 : 0;
        if (e.sat == 1 && m_cnt < 255) m_cnt++;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // Monitor: every handshake on the output pops one expected word.
    always @(negedge clk) begin
        if (rst || !ena) check("in_ready_blocked", int'(in_ready), 0);
        if (!rst && ena && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got u=%0d, expected no output", $signed(u));
            end else begin
                mon_e = q.pop_front();
                check("u", int'($signed(u)), mon_e.u);
                check("sat", int'(sat), mon_e.sat);
                check("sat_count", int'(sat_count), mon_e.cnt);
            end
        end
    end

    // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next one.
    task automatic step(input logic v, input int p, input int i, input int d,
                        input logic ordy, input logic en, output logic acc);
        logic [31:0] pv, iv, dv;
        pv = p; iv = i; dv = d;
        in_valid  = v;
        p_contrib = pv[W-1:0];
        i_contrib = iv[W-1:0];
        d_contrib = dv[W-1:0];
        out_ready = ordy;
        ena       = en;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        if (acc) model_push(p, i, d);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input logic ordy, input logic en);
        logic acc;
        step(1'b0, 0, 0, 0, ordy, en, acc);
    endtask

    task automatic send(input int p, input int i, input int d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, p, i, d, 1'b1, 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            idle(1'b1, 1'b1);
            k++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        idle(1'b1, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b1;
        p_contrib = 6'd5;
        i_contrib = '0;
        d_contrib = '0;
        q.delete();
        m_prev = 0;
        m_cnt  = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_u", int'($signed(u)), 0);
            check("rst_sat_count", int'(sat_count), 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic acc;
        int   p, i, d;
        @(posedge clk);
        #1;

        // Reset with input pending, then first-accept latency.
        do_reset(3);
        send(5, 0, 0);
        check("lat_edge1_valid", int'(out_valid), 0);
        idle(1'b1, 1'b1);
        check("lat_edge2_valid", int'(out_valid), 1);
        drain();

        // Basic sum and back-to-back stream.
        send(3, 4, -2);
        check("basic_edge1_valid", int'(out_valid), 0);
        idle(1'b0, 1'b1);
        check("basic_valid", int'(out_valid), 1);
        check("basic_u_head", int'($signed(u)), q[0].u);
        drain();
        send(1, 0, 0);
        send(2, 0, 0);
        check("stream_u1", int'($signed(u)), q[0].u);
        send(3, 0, 0);
        check("stream_u2", int'($signed(u)), q[0].u);
        idle(1'b1, 1'b1);
        check("stream_u3", int'($signed(u)), q[0].u);
        check("stream_valid3", int'(out_valid), 1);
        drain();

        // Saturation at both rails and the exact upper edge.
        do_reset(1);
        send(31, 31, 31);
        drain();
        check("sat_count_1", int'(sat_count), 1);
        send(-32, -32, -1);
        drain();
        check("sat_count_2", int'(sat_count), 2);
        send(20, 11, 0);
        drain();
`ifndef PID_SUMMER_RATE_LIMIT_EN
        check("edge31_sat", int'(sat), 0);
        check("edge31_u", int'($signed(u)), 31);
`endif

        // Backpressure: 7 parks in the output, 9 in stage 1, further input refused.
        step(1'b1, 7, 0, 0, 1'b0, 1'b1, acc);
        check("bp_acc7", int'(acc), 1);
        step(1'b1, 9, 0, 0, 1'b0, 1'b1, acc);
        check("bp_acc9", int'(acc), 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 11, 0, 0, 1'b0, 1'b1, acc);
            check("bp_refused", int'(acc), 0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_u_hold", int'($signed(u)), q[0].u);
        end
        check("bp_depth", q.size(), 2);
        drain();
        check("bp_all_out", q.size(), 0);

        // Enable low mid-stream freezes everything.
        send(6, 0, 0);
        send(8, 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle(1'b1, 1'b0);
            check("frz_valid", int'(out_valid), 1);
            check("frz_u", int'($signed(u)), q[0].u);
            check("frz_cnt", int'(sat_count), q[0].cnt);
        end
        check("frz_depth", q.size(), 2);
        drain();

        // Rate-limit scenario (pure sums without the limiter).
        do_reset(1);
        for (int k = 0; k < 5; k++) send(20, 0, 0);
        send(-10, 0, 0);
        drain();

        // Randomized traffic with random enable and backpressure.
        for (int k = 0; k < 400; k++) begin
            p = int'($urandom_range(0, 63)) - 32;
            i = int'($urandom_range(0, 63)) - 32;
            d = int'($urandom_range(0, 63)) - 32;
            step(1'($urandom_range(0, 1)), p, i, d,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), acc);
        end
        drain();

        // Counter saturation.
        do_reset(1);
        for (int k = 0; k < 300; k++) send(31, 31, 31);
        drain();
        check("cnt_max", int'(sat_count), 255);
        send(-32, -32, -32);
        drain();
        check("cnt_hold", int'(sat_count), 255);

        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_control_summer.md
Name: pid_control_summer

Overview:
- Downstream stage of the proportional/integral/derivative multipliers in the PID controller.
- Takes the three signed contribution words, sums them in a 2-stage pipeline, and saturates the result to the control-word range.
- Presents the control word `u` to the output/PWM stage with a valid/ready handshake.
- Keeps a saturating count of clipped samples for debug readout.

Parameters:
- W, 6, width of each contribution and of `u`; two's complement, MSB is sign.
- CNT_W, 8, width of `sat_count`.
- MAX_STEP, 4, largest allowed |u(n) − u(n−1)|; used only when the rate limiter is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- ena  in  1  block enable. Low freezes all state.
- in_valid  in  1  the p/i/d contribution set is valid.
- in_ready  out  1  summer accepts the set this cycle.
- p_contrib  in  W  proportional contribution, signed.
- i_contrib  in  W  integral contribution, signed.
- d_contrib  in  W  derivative contribution, signed.
- out_valid  out  1  `u` is valid.
- out_ready  in  1  consumer accepts `u`.
- u  out  W  saturated control word, signed.
- sat  out  1  the current `u` was clipped (saturation or rate limit).
- sat_count  out  CNT_W  number of clipped samples delivered.

Behaviour:
- Reset (`rst`=1 at a clk edge):
  - s1_valid=0, out_valid=0, u=0, sat=0, sat_count=0, u_prev=0.
  - Reset overrides `ena` and any handshake in the same cycle.
  - Reset mid-pipeline discards in-flight data; no output is produced for it.
- Advance condition: `adv` = ena & (!out_valid | out_ready).
- in_ready = adv & !rst; combinational, no dependence on in_valid.
- Input accept: in_valid & in_ready. Accepted data reaches out_valid=1 on the 2nd rising edge after acceptance (latency 2).
- Full throughput: 1 set per cycle while out_ready=1.
- Stage 1 (on adv):
  - s1_sum ← sext(p) + sext(i), W+2 bits.
  - s1_d ← d_contrib.
  - s1_valid ← accept.
- Stage 2 (on adv):
  - if s1_valid:
    - full = s1_sum + sext(s1_d), W+2 bits; no overflow possible.
    - Clip full to [−2^(W−1), 2^(W−1)−1], i.e. [−32, 31] at defaults.
    - u ← clipped value; sat ← (clipped ≠ full); out_valid ← 1.
    - u_prev ← u_new.
    - sat_count increments when sat_new=1 and holds at all-ones (no wrap).
  - if !s1_valid and out_ready: out_valid ← 0; u and sat hold their last values.
- Backpressure:
  - out_valid=1 & out_ready=0 → u, sat, out_valid and stage 1 all hold; in_ready=0.
  - Output remains stable until accepted.
- ena=0: no register changes except reset; in_ready=0; out_valid holds its level.
- Simultaneous output accept and new stage-1 data: out_valid stays 1 and u updates on the same edge (no bubble).

Optional Feature:
- Macro: PID_SUMMER_RATE_LIMIT_EN.
- Defined:
  - After saturation, u_new = clamp(clipped, u_prev − MAX_STEP, u_prev + MAX_STEP).
  - Computation is in W+2 bits, so no wrap near the range ends.
  - sat=1 if either saturation or rate limiting altered the value.
  - u_prev resets to 0, so the first output after reset is within ±MAX_STEP of 0.
- Undefined: no limiter logic; u_new = clipped; u_prev unused.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 3 cycles with in_valid=1, p=5 → then release.
  - Required: during reset, out_valid=0, u=0, sat_count=0; after release, the first out_valid=1 occurs exactly 2 edges after the first accept.
- Basic sum:
  - Stimulus: p=3, i=4, d=−2, out_ready=1.
  - Required: u=5, sat=0, 2-cycle latency.
  - Stimulus: stream p=1,2,3 (i=d=0) on back-to-back cycles.
  - Required: u=1,2,3 on consecutive cycles.
- Saturation:
  - Stimulus: p=31, i=31, d=31.
  - Required: u=31, sat=1, sat_count=1.
  - Stimulus: p=−32, i=−32, d=−1.
  - Required: u=−32, sat=1, sat_count=2.
  - Stimulus: p=20, i=11, d=0.
  - Required: u=31, sat=0.
- Backpressure:
  - Stimulus: out_ready=0 while sending p=7 then p=9.
  - Required: u holds at 7 with out_valid=1; in_ready=0 after stage 1 fills.
  - Stimulus: raise out_ready.
  - Required: 7 is accepted, then 9 on the next cycle; nothing lost or duplicated.
- Enable and counter:
  - Stimulus: ena=0 for 5 cycles mid-stream.
  - Required: all outputs frozen; resume with ena=1 delivers the held data in order.
  - Stimulus: 300 saturating samples.
  - Required: sat_count=255, holds.
- Rate limit (macro defined, MAX_STEP=4):
  - Stimulus: after reset, p=20.
  - Required: u=4, then 8, 12, 16, 20 on repeated inputs; sat=1 until u=20.
  - Stimulus: then p=−10.
  - Required: u=16.
